// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: assembles a UART frame from per-bit samples; optional UART_RX_ERR_COUNT_EN adds err_count
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_based_on_prescale,
    input  logic                  rst,
    input  logic [5:0]            prescale,
    input  logic [5:0]            edge_count,
    input  logic                  sampled_data,
    input  logic                  deser_enable,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic                  busy
`ifdef UART_RX_ERR_COUNT_EN
    ,
    output logic [7:0]            err_count
`endif
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic [2:0] LAST = 3'(DATA_WIDTH - 1);
    state_t state, state_n;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [2:0] bit_idx;
    logic par_en_q, par_typ_q, par_fail;
    logic valid_n, par_n, stp_n, glitch_n;
    logic bit_end;
    assign bit_end = edge_count == prescale - 6'd1;
    assign busy = state != IDLE;
    // state register
    always_ff @(posedge clk_based_on_prescale) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end
    // next state and strobe decode; a dropped enable aborts silently
    always_comb begin
        state_n  = state;
        valid_n  = 1'b0;
        par_n    = 1'b0;
        stp_n    = 1'b0;
        glitch_n = 1'b0;
        if (state != IDLE && !deser_enable) state_n = IDLE;
        else begin
            case (state)
                IDLE:    state_n = deser_enable ? START : IDLE;
                START:   if (bit_end) begin
                             state_n  = sampled_data ? IDLE : DATA;
                             glitch_n = sampled_data;
                         end
                DATA:    if (bit_end && bit_idx == LAST) state_n = par_en_q ? PARITY : STOP;
                PARITY:  if (bit_end) state_n = STOP;
                STOP:    if (bit_end) begin
                             state_n = IDLE;
                             stp_n   = !sampled_data;
                             par_n   = par_fail;
                             valid_n = sampled_data && !par_fail;
                         end
                default: state_n = IDLE;
            endcase
        end
    end
    // datapath: bit capture, frame config latch, parity check, registered strobes
    always_ff @(posedge clk_based_on_prescale) begin
        if (!rst) begin
            shift_reg   <= '0;
            bit_idx     <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            par_fail    <= 1'b0;
            p_data      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
        end else begin
            if (state == START && state_n == DATA) begin
                bit_idx   <= '0;
                par_en_q  <= par_en;
                par_typ_q <= par_typ;
                par_fail  <= 1'b0;
            end
            if (state == DATA && state_n != IDLE && bit_end) begin
                shift_reg[bit_idx] <= sampled_data;
                bit_idx            <= bit_idx + 3'd1;
            end
            if (state == PARITY && state_n == STOP) par_fail <= sampled_data != (^shift_reg ^ par_typ_q);
            p_data      <= valid_n ? shift_reg : p_data;
            data_valid  <= valid_n;
            par_err     <= par_n;
            stp_err     <= stp_n;
            strt_glitch <= glitch_n;
        end
    end
`ifdef UART_RX_ERR_COUNT_EN
    // saturating count of frames that raised any error strobe
    always_ff @(posedge clk_based_on_prescale) begin
        if (!rst) err_count <= '0;
        else if ((par_n || stp_n || glitch_n) && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed frame tests for uart_rx_deserializer
module tb_uart_rx_deserializer;
    logic clk = 1'b0;
    logic rst, sampled_data, deser_enable, par_en, par_typ;
    logic [5:0] prescale, edge_count;
    logic [7:0] p_data;
    logic data_valid, par_err, stp_err, strt_glitch, busy;
`ifdef UART_RX_ERR_COUNT_EN
    logic [7:0] err_count;
`endif
    int tests = 0;
    int fails = 0;
    int ps = 8;

    uart_rx_deserializer #(.DATA_WIDTH(8)) dut (
        .clk_based_on_prescale(clk),
        .rst(rst),
        .prescale(prescale),
        .edge_count(edge_count),
        .sampled_data(sampled_data),
        .deser_enable(deser_enable),
        .par_en(par_en),
        .par_typ(par_typ),
        .p_data(p_data),
        .data_valid(data_valid),
        .par_err(par_err),
        .stp_err(stp_err),
        .strt_glitch(strt_glitch),
        .busy(busy)
`ifdef UART_RX_ERR_COUNT_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        prescale = 6'(ps);
        for (int b = 0; b < n; b++)
            for (int e = 0; e < ps; e++) begin
                edge_count   = 6'(e);
                sampled_data = bits[b];
                deser_enable = 1'b1;
                tick();
            end
    endtask

    task automatic idle_cycle();
        deser_enable = 1'b0;
        edge_count   = 6'd0;
        sampled_data = 1'b1;
        tick();
    endtask

    task automatic check_out(input string name, input logic [7:0] pd, input logic [4:0] flags);
        logic [4:0] got;
        got = {data_valid, par_err, stp_err, strt_glitch, busy};
        tests++;
        if (got !== flags || p_data !== pd) begin
            fails++;
            $display("FAIL %s: got p_data=%h v/pe/se/sg/busy=%b, expected p_data=%h flags=%b", name, p_data, got, pd, flags);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        check_out("reset", 8'h00, 5'b00000);
        rst = 1'b1;
        idle_cycle();
        check_out("idle_after_reset", 8'h00, 5'b00000);
    endtask

    task automatic test_good_frame();
        ps = 8; par_en = 1'b1; par_typ = 1'b0;
        send_bits({1'b1, 1'b0, 8'hA5, 1'b0}, 11);
        check_out("good_a5", 8'hA5, 5'b10000);
        idle_cycle();
        check_out("good_a5_strobe_end", 8'hA5, 5'b00000);
    endtask

    task automatic test_parity_error();
        send_bits({1'b1, 1'b1, 8'hA5, 1'b0}, 11);
        check_out("parity_err", 8'hA5, 5'b01000);
        idle_cycle();
        check_out("parity_err_end", 8'hA5, 5'b00000);
    endtask

    task automatic test_back_to_back();
        ps = 16; par_en = 1'b0;
        send_bits({1'b0, 1'b0, 8'h3C, 1'b0}, 10);
        check_out("stop_err", 8'hA5, 5'b00100);
        send_bits({1'b0, 1'b1, 8'h81, 1'b0}, 10);
        check_out("b2b_81", 8'h81, 5'b10000);
        idle_cycle();
        check_out("b2b_end", 8'h81, 5'b00000);
    endtask

    task automatic test_glitch();
        ps = 8;
        send_bits(11'h001, 1);
        check_out("glitch", 8'h81, 5'b00010);
        idle_cycle();
        check_out("glitch_end", 8'h81, 5'b00000);
        idle_cycle();
        check_out("glitch_quiet", 8'h81, 5'b00000);
    endtask

    task automatic test_mid_reset();
        send_bits({1'b1, 1'b0, 8'hFF, 1'b0}, 5);
        check_out("mid_busy", 8'h81, 5'b00001);
        for (int e = 0; e < 3; e++) begin
            edge_count = 6'(e);
            tick();
        end
        rst = 1'b0;
        tick();
        check_out("mid_reset", 8'h00, 5'b00000);
        rst = 1'b1;
        idle_cycle();
        ps = 16;
        send_bits({1'b0, 1'b1, 8'h12, 1'b0}, 10);
        check_out("after_reset_12", 8'h12, 5'b10000);
        idle_cycle();
    endtask

    task automatic test_enable_drop();
        ps = 8;
        send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 3);
        check_out("drop_busy", 8'h12, 5'b00001);
        idle_cycle();
        check_out("drop_idle", 8'h12, 5'b00000);
        for (int i = 0; i < 12; i++) idle_cycle();
        check_out("drop_quiet", 8'h12, 5'b00000);
    endtask

    task automatic test_odd_parity();
        ps = 32; par_en = 1'b1; par_typ = 1'b1;
        send_bits({1'b1, 1'b0, 8'h13, 1'b0}, 11);
        check_out("odd_ok_13", 8'h13, 5'b10000);
        idle_cycle();
        send_bits({1'b1, 1'b0, 8'h12, 1'b0}, 11);
        check_out("odd_bad_12", 8'h13, 5'b01000);
        idle_cycle();
    endtask

    task automatic test_cfg_latch();
        ps = 8; par_en = 1'b1; par_typ = 1'b0;
        send_bits({1'b1, 1'b0, 8'h0F, 1'b0}, 2);
        par_en = 1'b0; par_typ = 1'b1;
        send_bits({1'b1, 1'b0, 8'h0F, 1'b0} >> 2, 9);
        check_out("cfg_latched_0f", 8'h0F, 5'b10000);
        idle_cycle();
    endtask

`ifdef UART_RX_ERR_COUNT_EN
    task automatic test_err_count();
        tests++;
        if (err_count !== 8'd0) begin
            fails++;
            $display("FAIL err_count_start: got %0d expected 0", err_count);
        end
        ps = 8;
        for (int i = 0; i < 300; i++) begin
            send_bits(11'h001, 1);
            idle_cycle();
        end
        tests++;
        if (err_count !== 8'd255) begin
            fails++;
            $display("FAIL err_count_sat: got %0d expected 255", err_count);
        end
        par_en = 1'b0;
        send_bits({1'b0, 1'b1, 8'h66, 1'b0}, 10);
        check_out("err_good_66", 8'h66, 5'b10000);
        tests++;
        if (err_count !== 8'd255) begin
            fails++;
            $display("FAIL err_count_hold: got %0d expected 255", err_count);
        end
        idle_cycle();
    endtask
`endif

    initial begin
        rst = 1'b0; sampled_data = 1'b1; deser_enable = 1'b0;
        par_en = 1'b0; par_typ = 1'b0; prescale = 6'd8; edge_count = 6'd0;
        test_reset();
        test_good_frame();
        test_parity_error();
        test_back_to_back();
        test_glitch();
        test_mid_reset();
        test_enable_drop();
        test_odd_parity();
        test_cfg_latch();
`ifdef UART_RX_ERR_COUNT_EN
        test_err_count();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Downstream of the data sampler in the UART RX path; consumes `sampled_data` once per bit period and assembles a complete frame: start, DATA_WIDTH data bits LSB first, optional parity, stop.
- Checks start, parity and stop bits, then presents the parallel byte with a one-cycle `data_valid` strobe.
- Runs on the oversampling clock and uses the same `edge_count` and `prescale` as the sampler.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal range 5..8).

Ports:
- clk_based_on_prescale  in  1  oversampling clock, prescale ticks per bit.
- rst  in  1  synchronous active-low reset.
- prescale  in  6  oversampling ratio; legal values 8, 16, 32.
- edge_count  in  6  position within the current bit; 0..prescale-1 from the edge counter.
- sampled_data  in  1  majority-voted bit from the data sampler.
- deser_enable  in  1  high for the whole frame; first cycle is edge_count==0 of the start bit.
- par_en  in  1  1 = frame contains a parity bit.
- par_typ  in  1  0 = even parity, 1 = odd parity.
- p_data  out  DATA_WIDTH  last good frame's data.
- data_valid  out  1  one-cycle strobe; p_data is new.
- par_err  out  1  one-cycle strobe; parity mismatch.
- stp_err  out  1  one-cycle strobe; stop bit sampled 0.
- strt_glitch  out  1  one-cycle strobe; start bit sampled 1.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Clocking and reset: single clock; every register updates on the rising edge. `rst`=0 at any edge forces IDLE, clears the shift register and bit index, and drives all outputs to 0, including mid-frame.
- bit_end: `edge_count == prescale-1`. The sampler's vote completes at prescale/2+1, so `sampled_data` is stable at bit_end. All captures and state transitions happen only on bit_end cycles.
- IDLE: busy=0. When deser_enable=1, go to START on the next edge.
- START, at bit_end:
  - sampled_data=0: go to DATA, bit index = 0.
  - sampled_data=1: strt_glitch=1 for one cycle, go to IDLE.
- DATA, at bit_end:
  - Capture sampled_data into shift register position bit_index (LSB first), then increment bit_index.
  - After bit index DATA_WIDTH-1: go to PARITY if par_en=1, else STOP.
- PARITY, at bit_end:
  - Expected bit = XOR of the data bits, inverted when par_typ=1.
  - Latch internal parity-fail flag = (sampled_data != expected). Go to STOP.
- STOP, at bit_end, then go to IDLE:
  - sampled_data=0: stp_err=1.
  - Parity-fail flag set: par_err=1.
  - Both checks pass: p_data <= shift register and data_valid=1 for one cycle.
  - p_data otherwise holds its previous value.
  - Multiple error strobes may assert together.
- par_en and par_typ are sampled once, at the START→DATA transition; changes mid-frame are ignored.
- deser_enable dropping to 0 in any non-IDLE state: go to IDLE next edge, no strobes, p_data unchanged.
- Back-to-back frames: deser_enable held high through STOP → IDLE → START on consecutive edges. Worst-case turnaround is 2 clocks, which is less than prescale.
- Latency: data_valid asserts in the cycle after the stop bit's bit_end edge.
- An illegal prescale value gives undefined results; no checking is done.

Optional Feature:
- Macro: UART_RX_ERR_COUNT_EN.
- Defined: adds output `err_count` (8 bits).
  - Increments once per frame that raises any of par_err, stp_err or strt_glitch; saturates at 255.
  - Cleared only by rst.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- prescale=8, par_en=1, par_typ=0, frame 0xA5 (bits 1,0,1,0,0,1,0,1; parity 0; stop 1) → data_valid one cycle, p_data=0xA5, no error strobes.
- Same frame, parity bit driven 1 → par_err=1, data_valid=0, p_data keeps its old value.
- prescale=16, par_en=0, frame 0x3C with stop=0 → stp_err=1, no data_valid. Next frame 0x81 back-to-back → p_data=0x81.
- Start bit sampled 1 at bit_end → strt_glitch one cycle, busy=0 on the next edge, no further strobes.
- rst=0 during data bit 4 of 0xFF, then a clean frame 0x12 → all outputs 0 after reset, then p_data=0x12 with data_valid.
- With UART_RX_ERR_COUNT_EN: 300 bad frames → err_count=255; a good frame leaves it at 255.
